// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_FLAG_EN to add the div_by_zero output flag.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
`ifdef DIV_ZERO_FLAG_EN
    output logic        div_by_zero,
`endif
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d, shl;
    logic [31:0] dvs_q, dvs_d, quot_q, quot_d, rem_q, rem_d, mag1, mag2;
    logic [32:0] diff;
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, a_neg, b_neg;
    assign a_neg = div_signed & div_src1[31];
    assign b_neg = div_signed & div_src2[31];
    assign mag1  = a_neg ? -div_src1 : div_src1;
    assign mag2  = b_neg ? -div_src2 : div_src2;
    // acc holds {partial remainder, dividend/quotient bits}; shifted left each step
    assign shl   = acc_q << 1;
    assign diff  = {1'b0, shl[63:32]} - {1'b0, dvs_q};
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: if (div_start) begin
                if (div_src2 == 32'd0) begin
                    quot_d  = '1;
                    rem_d   = div_src1;
                    state_d = DONE;
                end else begin
                    acc_d   = {32'd0, mag1};
                    dvs_d   = mag2;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = 6'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = diff[32] ? shl : {diff[31:0], shl[31:0] | 32'd1};
                cnt_d   = cnt_q + 6'd1;
                state_d = (cnt_q == 6'd31) ? FIX : CALC;
            end
            FIX: begin
                quot_d  = qneg_q ? -acc_q[31:0] : acc_q[31:0];
                rem_d   = rneg_q ? -acc_q[63:32] : acc_q[63:32];
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
    assign div_busy      = (state_q == CALC) || (state_q == FIX);
    assign div_done      = (state_q == DONE);
    assign div_quotient  = quot_q;
    assign div_remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
    logic dz_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            dz_q <= 1'b0;
        else if (state_q == IDLE && div_start)
            dz_q <= (div_src2 == 32'd0);
    end
    assign div_by_zero = div_done & dz_q;
`endif
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table, directed corner sequences and random checks of div_unit.
module tb_div_unit;
    logic        clk = 1'b0, resetn = 1'b0, div_start = 1'b0, div_signed = 1'b0;
    logic [31:0] div_src1 = '0, div_src2 = '0;
    logic        div_busy, div_done;
    logic [31:0] div_quotient, div_remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_by_zero;
`endif
    int n_checks = 0, n_err = 0;
    always #5 clk = ~clk;
    div_unit dut (
        .clk(clk), .resetn(resetn), .div_start(div_start), .div_signed(div_signed),
        .div_src1(div_src1), .div_src2(div_src2),
`ifdef DIV_ZERO_FLAG_EN
        .div_by_zero(div_by_zero),
`endif
        .div_busy(div_busy), .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );
    typedef struct {
        logic        s;
        logic [31:0] a, b, q, r;
        int          lat;
    } vec_t;
    vec_t vecs[10];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask
    // Edge 0 accepts the request; "value at edge k" is sampled on the negedge before edge k.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int poke, input logic rel, output int lat, output int busy_n,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        @(negedge clk);
        if (rel) resetn = 1'b1;
        div_start = 1'b1; div_signed = s; div_src1 = a; div_src2 = b;
        @(posedge clk);
        #1 div_start = 1'b0;
        lat = -1; busy_n = 0; q = '0; r = '0; dz = 1'b0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            div_start = (k == poke);
            if (k == poke) begin
                div_signed = ~s; div_src1 = 32'h0BAD_F00D; div_src2 = 32'd3;
            end
            if (div_busy) busy_n++;
            if (div_done) begin
                lat = k; q = div_quotient; r = div_remainder;
`ifdef DIV_ZERO_FLAG_EN
                dz = div_by_zero;
`endif
            end
            @(posedge clk);
        end
        div_start = 1'b0;
    endtask
    initial begin
        int lat, busy_n, dones;
        logic [31:0] q, r, eq, er;
        logic dz, s;
        logic [31:0] a, b;
        vecs[0] = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        34};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 34};
        vecs[2] = '{1'b0, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        34};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        34};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 34};
        vecs[6] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        34};
        vecs[7] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 34};
        vecs[8] = '{1'b1, 32'h8000_0000, 32'd0,        32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9] = '{1'b0, 32'd5,         32'd10,       32'd0,        32'd5,        34};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(div_busy), 32'd0);
        check("reset_done", 32'(div_done), 32'd0);
        check("reset_quot", div_quotient, 32'd0);
        check("reset_rem", div_remainder, 32'd0);
        // First request rides on the very edge after reset release; consecutive runs are back-to-back.
        foreach (vecs[i]) begin
            run_div(vecs[i].s, vecs[i].a, vecs[i].b, 0, i == 0, lat, busy_n, q, r, dz);
            check($sformatf("vec%0d_quot", i), q, vecs[i].q);
            check($sformatf("vec%0d_rem", i), r, vecs[i].r);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), 32'(busy_n), vecs[i].lat == 1 ? 32'd0 : 32'd33);
`ifdef DIV_ZERO_FLAG_EN
            check($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].b == 32'd0));
`endif
        end
        run_div(1'b0, 32'd100, 32'd7, 10, 1'b0, lat, busy_n, q, r, dz);
        check("poke_quot", q, 32'd14);
        check("poke_rem", r, 32'd2);
        check("poke_lat", 32'(lat), 32'd34);
        @(negedge clk);
        check("done_one_cycle", 32'(div_done), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_quot", div_quotient, 32'd14);
        check("hold_rem", div_remainder, 32'd2);
        div_start = 1'b1; div_signed = 1'b0; div_src1 = 32'h1234_5678; div_src2 = 32'd3;
        @(posedge clk);
        #1 div_start = 1'b0;
        repeat (20) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_quot", div_quotient, 32'd0);
        check("midrst_rem", div_remainder, 32'd0);
        check("midrst_busy", 32'(div_busy), 32'd0);
        check("midrst_done", 32'(div_done), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_done || div_busy) dones++;
        end
        check("midrst_no_activity", 32'(dones), 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 0, 1'b0, lat, busy_n, q, r, dz);
        check("after_rst_quot", q, 32'd3);
        check("after_rst_rem", r, 32'd0);
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = $urandom_range(0, 15);
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (sel == 0) ? 32'd0 : (sel < 6) ? 32'($urandom_range(1, 20)) : $urandom;
            if (sel == 15) begin
                a = 32'h8000_0000; b = '1;
            end
            model(s, a, b, eq, er);
            run_div(s, a, b, 0, 1'b0, lat, busy_n, q, r, dz);
            check($sformatf("rnd%0d_quot(%h/%h s%0d)", i, a, b, s), q, eq);
            check($sformatf("rnd%0d_rem", i), r, er);
            check($sformatf("rnd%0d_lat", i), 32'(lat), b == 32'd0 ? 32'd1 : 32'd34);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
